// File: rtl/hazard_control_unit_pkg.sv
// Shared definitions for the hazard control unit: FSM encodings, register
// constants, the legal FLUSH_CYCLES range and the load-use detection function.
package hazard_control_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int FLUSH_CYCLES_MIN = 1;
  localparam int FLUSH_CYCLES_MAX = 4;

  // A load in EX whose destination feeds a source of the instruction in ID.
  function automatic logic load_use(
    input logic       ex_mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       id_uses_rt
  );
    return ex_mem_read && (ex_rt != REG_ZERO) &&
           ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_perf_counter.sv
// Saturating 32-bit event counter with enable, cleared by asynchronous reset.
module hazard_perf_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  output logic [31:0] count
);

  // NOTE: sequential state is written only with <= inside always_ff so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 32'd1;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline hazard control for the IF/ID and ID/EX registers: load-use stalls,
// multi-cycle branch flushes and memory-wait freezes. Define HAZARD_PERF_CNT_EN
// to add the stall_cycles/flush_cycles performance counters.
module hazard_control_unit
  import hazard_control_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic        id_uses_rt,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rt,
  input  logic        ex_branch_taken,
  input  logic        mem_busy,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_write,
  output logic        idex_bubble,
  output logic [1:0]  state
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_cycles
`endif
);

  // Remaining flush cycles after the one in which the branch resolves.
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (FLUSH_CYCLES > FLUSH_CYCLES_MIN) ? CNT_W'(FLUSH_CYCLES - 2) : '0;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             in_flush;
  logic             lu;
  logic             stall_evt;

  // Encodings other than ST_FLUSH behave as RUN.
  assign in_flush = (state_q == ST_FLUSH);
  assign lu       = load_use(ex_mem_read, ex_rt, id_rs, id_rt, id_uses_rt);
  assign state    = state_q;

  // NOTE: every output gets a default before the priority chain so no path
  // leaves a signal unassigned and infers a latch.
  always_comb begin
    pc_write    = 1'b0;
    ifid_write  = 1'b0;
    ifid_flush  = 1'b0;
    idex_write  = 1'b0;
    idex_bubble = 1'b0;
    stall_evt   = 1'b0;
    if (reset) begin
      // everything held off while in reset
    end else if (mem_busy) begin
      stall_evt = 1'b1;
    end else if (ex_branch_taken || in_flush) begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      ifid_flush  = 1'b1;
      idex_write  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu) begin
      idex_write  = 1'b1;
      idex_bubble = 1'b1;
      stall_evt   = 1'b1;
    end else begin
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
    end
  end

  // A freeze holds state and counter so a pending flush resumes afterwards.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else if (!mem_busy) begin
      if (ex_branch_taken) begin
        if (FLUSH_CYCLES > FLUSH_CYCLES_MIN) begin
          state_q <= ST_FLUSH;
          cnt_q   <= CNT_LOAD;
        end else begin
          state_q <= ST_RUN;
          cnt_q   <= '0;
        end
      end else if (in_flush) begin
        if (cnt_q == '0) begin
          state_q <= ST_RUN;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end else begin
        state_q <= ST_RUN;
        cnt_q   <= '0;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_counter u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (stall_evt),
    .count (stall_cycles)
  );

  hazard_perf_counter u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (ifid_flush),
    .count (flush_cycles)
  );
`else
  logic unused_stall_evt;
  assign unused_stall_evt = stall_evt;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit with FLUSH_CYCLES=3: the driver
// pushes hand-computed expectations, a negedge monitor pops and compares.
module tb_hazard_control_unit;

  // Output vector order: {pc_write, ifid_write, ifid_flush, idex_write, idex_bubble}
  localparam logic [4:0] O_RUN   = 5'b11010;
  localparam logic [4:0] O_STALL = 5'b00011;
  localparam logic [4:0] O_FLUSH = 5'b11111;
  localparam logic [4:0] O_OFF   = 5'b00000;

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] outs;
    logic [1:0] st;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rt;
  logic        id_uses_rt, ex_mem_read, ex_branch_taken, mem_busy;
  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_bubble;
  logic [1:0]  state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_cycles;
  int unsigned model_stall = 0;
  int unsigned model_flush = 0;
`endif

  exp_t sb_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  hazard_control_unit #(.FLUSH_CYCLES(3), .CNT_W(3)) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_uses_rt      (id_uses_rt),
    .ex_mem_read     (ex_mem_read),
    .ex_rt           (ex_rt),
    .ex_branch_taken (ex_branch_taken),
    .mem_busy        (mem_busy),
    .pc_write        (pc_write),
    .ifid_write      (ifid_write),
    .ifid_flush      (ifid_flush),
    .idex_write      (idex_write),
    .idex_bubble     (idex_bubble),
    .state           (state)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .stall_cycles    (stall_cycles),
    .flush_cycles    (flush_cycles)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs just after the rising edge and queue the expectation.
  task automatic cyc(input string name, input logic rst,
                     input logic [4:0] rs, input logic [4:0] rt, input logic use_rt,
                     input logic mrd, input logic [4:0] xrt,
                     input logic br, input logic busy,
                     input logic [4:0] eo, input logic [1:0] es);
    exp_t e;
    @(posedge clk);
    #1;
    reset           = rst;
    id_rs           = rs;
    id_rt           = rt;
    id_uses_rt      = use_rt;
    ex_mem_read     = mrd;
    ex_rt           = xrt;
    ex_branch_taken = br;
    mem_busy        = busy;
    e.name = name;
    e.rst  = rst;
    e.outs = eo;
    e.st   = es;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    while (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      check({mon_e.name, " outs"},
            32'({pc_write, ifid_write, ifid_flush, idex_write, idex_bubble}),
            32'(mon_e.outs));
      check({mon_e.name, " state"}, 32'(state), 32'(mon_e.st));
`ifdef HAZARD_PERF_CNT_EN
      if (mon_e.rst) begin
        model_stall = 0;
        model_flush = 0;
      end
      check({mon_e.name, " stall_cycles"}, stall_cycles, model_stall);
      check({mon_e.name, " flush_cycles"}, flush_cycles, model_flush);
      if (!mon_e.rst) begin
        if (mon_e.outs == O_OFF || mon_e.outs == O_STALL) model_stall++;
        if (mon_e.outs[2]) model_flush++;
      end
`endif
    end
  end

  initial begin
    reset = 1'b1;
    id_rs = '0; id_rt = '0; ex_rt = '0;
    id_uses_rt = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0; mem_busy = 1'b0;

    //   name             rst rs     rt     use  mrd xrt    br   busy  outs     st
    cyc("reset0",         1, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,    O_OFF,   2'd0);
    cyc("reset1",         1, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,    O_OFF,   2'd0);
    cyc("idle",           0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,    O_RUN,   2'd0);
    cyc("lu_rs",          0, 5'd8,  5'd2,  0,   1,  5'd8,  0,   0,    O_STALL, 2'd0);
    cyc("lu_clear",       0, 5'd8,  5'd2,  0,   0,  5'd0,  0,   0,    O_RUN,   2'd0);
    cyc("lu_rt",          0, 5'd3,  5'd9,  1,   1,  5'd9,  0,   0,    O_STALL, 2'd0);
    cyc("rt_not_used",    0, 5'd3,  5'd9,  0,   1,  5'd9,  0,   0,    O_RUN,   2'd0);
    cyc("zero_reg",       0, 5'd0,  5'd0,  1,   1,  5'd0,  0,   0,    O_RUN,   2'd0);
    cyc("no_match",       0, 5'd6,  5'd7,  1,   1,  5'd5,  0,   0,    O_RUN,   2'd0);
    cyc("busy_lu",        0, 5'd8,  5'd0,  0,   1,  5'd8,  0,   1,    O_OFF,   2'd0);
    // Three-cycle flush
    cyc("br_c1",          0, 5'd0,  5'd0,  0,   0,  5'd0,  1,   0,    O_FLUSH, 2'd0);
    cyc("br_c2",          0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,    O_FLUSH, 2'd1);
    cyc("br_c3",          0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,    O_FLUSH, 2'd1);
    cyc("br_done",        0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,    O_RUN,   2'd0);
    // Branch beats load-use; load-use ignored during FLUSH
    cyc("br_and_lu",      0, 5'd4,  5'd0,  0,   1,  5'd4,  1,   0,    O_FLUSH, 2'd0);
    cyc("flush_lu",       0, 5'd4,  5'd0,  0,   1,  5'd4,  0,   0,    O_FLUSH, 2'd1);
    cyc("flush_lu2",      0, 5'd4,  5'd0,  0,   1,  5'd4,  0,   0,    O_FLUSH, 2'd1);
    cyc("after_flush",    0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,    O_RUN,   2'd0);
    // Freeze right after the branch
    cyc("frz_br",         0, 5'd0,  5'd0,  0,   0,  5'd0,  1,   0,    O_FLUSH, 2'd0);
    cyc("frz_busy1",      0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,    O_OFF,   2'd1);
    cyc("frz_busy2",      0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   1,    O_OFF,   2'd1);
    cyc("frz_resume1",    0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,    O_FLUSH, 2'd1);
    cyc("frz_resume2",    0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,    O_FLUSH, 2'd1);
    cyc("frz_done",       0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,    O_RUN,   2'd0);
    // Busy together with branch and load-use: nothing happens
    cyc("busy_all",       0, 5'd4,  5'd0,  0,   1,  5'd4,  1,   1,    O_OFF,   2'd0);
    cyc("busy_all_after", 0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,    O_RUN,   2'd0);
    // Branch during FLUSH restarts the counter
    cyc("rst_br1",        0, 5'd0,  5'd0,  0,   0,  5'd0,  1,   0,    O_FLUSH, 2'd0);
    cyc("rst_f1",         0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,    O_FLUSH, 2'd1);
    cyc("rst_br2",        0, 5'd0,  5'd0,  0,   0,  5'd0,  1,   0,    O_FLUSH, 2'd1);
    cyc("rst_f2",         0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,    O_FLUSH, 2'd1);
    cyc("rst_f3",         0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,    O_FLUSH, 2'd1);
    cyc("rst_done",       0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,    O_RUN,   2'd0);
    // Asynchronous reset mid-FLUSH, asserted between clock edges
    cyc("mid_br",         0, 5'd0,  5'd0,  0,   0,  5'd0,  1,   0,    O_FLUSH, 2'd0);
    cyc("mid_f",          0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,    O_FLUSH, 2'd1);
    cyc("mid_reset",      1, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,    O_OFF,   2'd0);
    cyc("mid_reset_hold", 1, 5'd0,  5'd0,  0,   0,  5'd0,  1,   0,    O_OFF,   2'd0);
    cyc("post_reset",     0, 5'd0,  5'd0,  0,   0,  5'd0,  0,   0,    O_RUN,   2'd0);
    cyc("post_reset_lu",  0, 5'd12, 5'd0,  0,   1,  5'd12, 0,   0,    O_STALL, 2'd0);

    for (int i = 0; i < 4 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations never compared, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
- Drives the pipeline-control side of the IF/ID and ID/EX stage registers. It decides, every cycle, whether each register advances, holds, or loads a bubble.
- Consumes the decoded operand fields of the instruction in ID and the control/destination fields leaving ID/EX.
- Detects load-use hazards, taken-branch flushes and external memory-wait freezes.
- Holds a small FSM so multi-cycle flushes survive freezes.

Parameters:
- FLUSH_CYCLES, 1, total cycles ifid_flush stays asserted per taken branch; legal 1..4.
- CNT_W, 3, width of the internal flush down-counter; must hold FLUSH_CYCLES-1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- id_rs  input  5  rs field of the instruction in ID
- id_rt  input  5  rt field of the instruction in ID
- id_uses_rt  input  1  instruction in ID reads rt as a source (R-type, beq, sw)
- ex_mem_read  input  1  Ctrl_MemRead of the instruction currently in EX (ID/EX output)
- ex_rt  input  5  rt of the instruction in EX (load destination)
- ex_branch_taken  input  1  beq in EX resolved taken this cycle
- mem_busy  input  1  data memory wait; whole front end must freeze
- pc_write  output  1  PC register load enable
- ifid_write  output  1  IF/ID load enable
- ifid_flush  output  1  IF/ID loads NOP (overrides ifid_write)
- idex_write  output  1  ID/EX load enable
- idex_bubble  output  1  ID/EX loads all-zero control fields
- state  output  2  FSM state: 0 RUN, 1 FLUSH

Behaviour:
- FSM state and flush counter are registered; all control outputs are combinational from state, counter and inputs.
- On reset assertion: state=RUN, counter=0, immediately and asynchronously.
- While reset is high: pc_write=0, ifid_write=0, idex_write=0, ifid_flush=0, idex_bubble=0.
- Load-use hazard signal: lu = ex_mem_read & (ex_rt!=0) & (ex_rt==id_rs | (id_uses_rt & ex_rt==id_rt)).
- Output priority per cycle, highest first:
  1. mem_busy=1: all five outputs 0; state and counter hold. The pipeline freezes; any pending flush resumes after the freeze.
  2. ex_branch_taken=1 (any state): pc_write=1, ifid_write=1, ifid_flush=1, idex_write=1, idex_bubble=1. If FLUSH_CYCLES>1, next state=FLUSH and counter=FLUSH_CYCLES-2; otherwise stay RUN.
  3. state=FLUSH: pc_write=1, ifid_write=1, ifid_flush=1, idex_write=1, idex_bubble=1. lu is ignored because ID holds a wrong-path instruction. If counter==0, next state=RUN; else counter decrements.
  4. RUN with lu=1: pc_write=0, ifid_write=0, idex_write=1, idex_bubble=1. This is a single-cycle stall; the hazard clears once the bubble enters EX.
  5. RUN with no event: pc_write=1, ifid_write=1, idex_write=1, flush=0, bubble=0.
- Latency: hazard response is same-cycle (0 cycles); FSM transitions take effect at the next rising edge.
- Boundary conditions:
  - ex_rt==0 never stalls.
  - A taken branch during FLUSH restarts the counter.
  - Reset mid-FLUSH returns to RUN.
  - Counter never underflows.
  - Unused state encodings 2 and 3 decode as RUN and transition to RUN.

Optional Feature:
- Macro: HAZARD_PERF_CNT_EN.
- When defined:
  - adds output stall_cycles (32) and output flush_cycles (32);
  - stall_cycles increments each cycle case 1 or case 4 applies;
  - flush_cycles increments each cycle ifid_flush=1;
  - both counters saturate at 0xFFFFFFFF and reset to 0.
- When undefined: neither port nor counter exists; behaviour is otherwise identical.

Decomposition:
- Shared package holds:
  - state encodings ST_RUN=2'd0, ST_FLUSH=2'd1;
  - REG_ZERO=5'd0;
  - the FLUSH_CYCLES legal range.
- Natural sub-module: hazard_perf_counter (saturating 32-bit counter with enable), instantiated twice under HAZARD_PERF_CNT_EN.

Test Plan:
- Load-use: ex_mem_read=1, ex_rt=8, id_rs=8 -> that cycle pc_write=0, ifid_write=0, idex_bubble=1; next cycle (ex_mem_read=0) all enables 1, bubble 0.
- Zero register: ex_mem_read=1, ex_rt=0, id_rs=0 -> no stall, pc_write=1.
- Branch with FLUSH_CYCLES=3: ex_branch_taken pulse -> ifid_flush=1 for exactly 3 consecutive cycles, state=1 for cycles 2-3, then RUN.
- Freeze mid-flush: FLUSH_CYCLES=3, mem_busy=1 for 2 cycles right after branch -> outputs 0 during busy, then remaining 2 flush cycles complete.
- Simultaneous events: ex_branch_taken=1 together with lu=1 -> flush wins (pc_write=1, ifid_flush=1); mem_busy=1 together with both -> all outputs 0.
- Reset mid-FLUSH: assert reset asynchronously between clock edges -> state=0 immediately and outputs 0; perf counters (if enabled) read 0.
